// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART blocks: parity modes, receiver
// state encoding and elaboration-time helpers for divider and counter sizing.
package uart_pkg;

    localparam int UART_CHECK_NONE = 0;
    localparam int UART_CHECK_ODD  = 1;
    localparam int UART_CHECK_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    // Rounded clocks-per-sample-tick, never below one.
    function automatic int calc_div(input int sys_clk, input int baud, input int os);
        int den;
        int div;
        den = baud * os;
        div = (sys_clk + den / 2) / den;
        return (div < 1) ? 1 : div;
    endfunction

    // Bits needed to count 0..n-1, at least one.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Sample-tick generator: one-cycle pulse every D clocks, held in phase reset
// while i_clr is high so the first tick lands D clocks after clear releases.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int P_SYSTEM_CLK    = 50_000_000,
    parameter int P_UART_BAUDRATE = 115200,
    parameter int P_OVERSAMPLE    = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int DIV = calc_div(P_SYSTEM_CLK, P_UART_BAUDRATE, P_OVERSAMPLE);
    localparam int CW  = cnt_width(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_reg;
    logic          tick_reg;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
        end else if (i_clr) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b1;
        end else begin
            cnt_reg  <= cnt_reg + 1'b1;
            tick_reg <= 1'b0;
        end
    end

    assign o_tick = tick_reg;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: majority vote of three centre samples per bit,
// configurable data/stop/parity, false-start rejection, parity/framing errors.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int P_SYSTEM_CLK      = 50_000_000,
    parameter int P_UART_BAUDRATE   = 115200,
    parameter int P_OVERSAMPLE      = 16,
    parameter int P_UART_DATA_WIDTH = 8,
    parameter int P_UART_STOP_WIDTH = 1,
    parameter int P_UART_CHECK      = 0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_uart_rx,
    output logic [P_UART_DATA_WIDTH-1:0] o_user_rx_data,
    output logic                         o_user_rx_valid,
    output logic                         o_user_rx_parity_err,
    output logic                         o_user_rx_frame_err,
    output logic                         o_rx_busy
);

    localparam int W  = P_UART_DATA_WIDTH;
    localparam int SW = cnt_width(P_OVERSAMPLE);
    localparam int BW = cnt_width(W);

    localparam logic [SW-1:0] S_LAST = SW'(P_OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_A    = SW'(P_OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_B    = SW'(P_OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_C    = SW'(P_OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(W - 1);
    localparam logic          STOP_LAST = (P_UART_STOP_WIDTH == 2);
    localparam logic          PAR_ODD   = (P_UART_CHECK == UART_CHECK_ODD);
    localparam bit            HAS_PAR   = (P_UART_CHECK != UART_CHECK_NONE);

    logic [1:0]    sync_reg;
    logic          rx_s;
    logic          tick;
    rx_state_t     state_reg;
    logic [SW-1:0] s_reg;
    logic [SW-1:0] s_next;
    logic          samp_a_reg;
    logic          samp_b_reg;
    logic          maj;
    logic          decide;
    logic          wrap;
    logic [BW-1:0] bit_cnt_reg;
    logic          stop_cnt_reg;
    logic [W-1:0]  shift_reg;
    logic          par_acc_reg;
    logic          perr_pend_reg;
    logic          ferr_pend_reg;
    logic [W-1:0]  data_reg;
    logic          valid_reg;
    logic          perr_reg;
    logic          ferr_reg;

    // Idle-high reset keeps reset release from looking like a start edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], i_uart_rx};
        end
    end

    assign rx_s = sync_reg[1];

    uart_baud_tick #(
        .P_SYSTEM_CLK    (P_SYSTEM_CLK),
        .P_UART_BAUDRATE (P_UART_BAUDRATE),
        .P_OVERSAMPLE    (P_OVERSAMPLE)
    ) u_baud_tick (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (state_reg == ST_IDLE),
        .o_tick (tick)
    );

    // s_next is the sample index a tick moves into; votes key off that index.
    always_comb begin
        s_next = s_reg;
        if (s_reg == S_LAST) begin
            s_next = '0;
        end else begin
            s_next = s_reg + 1'b1;
        end
    end

    assign decide = tick && (s_next == S_C);
    assign wrap   = tick && (s_reg == S_LAST);
    assign maj    = (samp_a_reg & samp_b_reg) | (samp_a_reg & rx_s) | (samp_b_reg & rx_s);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg     <= ST_IDLE;
            s_reg         <= '0;
            samp_a_reg    <= 1'b1;
            samp_b_reg    <= 1'b1;
            bit_cnt_reg   <= '0;
            stop_cnt_reg  <= 1'b0;
            shift_reg     <= '0;
            par_acc_reg   <= 1'b0;
            perr_pend_reg <= 1'b0;
            ferr_pend_reg <= 1'b0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            perr_reg      <= 1'b0;
            ferr_reg      <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            if (tick) begin
                s_reg <= s_next;
                if (s_next == S_A) samp_a_reg <= rx_s;
                if (s_next == S_B) samp_b_reg <= rx_s;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_reg     <= ST_START;
                        s_reg         <= '0;
                        bit_cnt_reg   <= '0;
                        stop_cnt_reg  <= 1'b0;
                        par_acc_reg   <= 1'b0;
                        perr_pend_reg <= 1'b0;
                        ferr_pend_reg <= 1'b0;
                    end
                end
                ST_START: begin
                    if (decide && maj) begin
                        state_reg <= ST_IDLE;
                    end else if (wrap) begin
                        state_reg <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (decide) begin
                        shift_reg   <= {maj, shift_reg[W-1:1]};
                        par_acc_reg <= par_acc_reg ^ maj;
                    end
                    if (wrap) begin
                        if (bit_cnt_reg == BIT_LAST) begin
                            state_reg <= HAS_PAR ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (decide) begin
                        perr_pend_reg <= ((par_acc_reg ^ maj) != PAR_ODD);
                    end
                    if (wrap) begin
                        state_reg <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // Complete at the last stop bit's centre for half-bit resync margin.
                    if (decide) begin
                        if (stop_cnt_reg == STOP_LAST) begin
                            data_reg  <= shift_reg;
                            perr_reg  <= perr_pend_reg;
                            ferr_reg  <= ferr_pend_reg | ~maj;
                            valid_reg <= 1'b1;
                            state_reg <= ST_IDLE;
                        end else begin
                            ferr_pend_reg <= ferr_pend_reg | ~maj;
                        end
                    end else if (wrap) begin
                        stop_cnt_reg <= ~stop_cnt_reg;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_user_rx_data       = data_reg;
    assign o_user_rx_valid      = valid_reg;
    assign o_user_rx_parity_err = perr_reg;
    assign o_user_rx_frame_err  = ferr_reg;
    assign o_rx_busy            = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench: four receivers (8N1, 8E1, 8O1, 8N2) on separate lines at
// 50 MHz / 115200 / OS16, one bit = 432 clocks.
module tb_uart_rx_os;

    localparam int BIT = 432;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] rx_line;
    logic [7:0] data_o [4];
    logic [3:0] valid_o;
    logic [3:0] perr_o;
    logic [3:0] ferr_o;
    logic [3:0] busy_o;

    int checks   = 0;
    int failures = 0;
    int vcnt [4] = '{0, 0, 0, 0};
    logic [7:0] cap_d [4][16];
    logic       cap_p [4][16];
    logic       cap_f [4][16];

    always #10 clk = ~clk;

    // ch0 8N1, ch1 even parity, ch2 odd parity, ch3 two stop bits
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        uart_rx_os #(
            .P_SYSTEM_CLK      (50_000_000),
            .P_UART_BAUDRATE   (115200),
            .P_OVERSAMPLE      (16),
            .P_UART_DATA_WIDTH (8),
            .P_UART_STOP_WIDTH (gi == 3 ? 2 : 1),
            .P_UART_CHECK      (gi == 1 ? 2 : (gi == 2 ? 1 : 0))
        ) u_dut (
            .i_clk                (clk),
            .i_rst                (rst),
            .i_uart_rx            (rx_line[gi]),
            .o_user_rx_data       (data_o[gi]),
            .o_user_rx_valid      (valid_o[gi]),
            .o_user_rx_parity_err (perr_o[gi]),
            .o_user_rx_frame_err  (ferr_o[gi]),
            .o_rx_busy            (busy_o[gi])
        );
    end

    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (valid_o[c] === 1'b1 && vcnt[c] < 16) begin
                cap_d[c][vcnt[c]] <= data_o[c];
                cap_p[c][vcnt[c]] <= perr_o[c];
                cap_f[c][vcnt[c]] <= ferr_o[c];
                vcnt[c]           <= vcnt[c] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_frame(input string tag, input int ch, input int idx,
                               input logic [7:0] d, input logic p, input logic f);
        check({tag, "_data"}, cap_d[ch][idx], d);
        check({tag, "_perr"}, cap_p[ch][idx], p);
        check({tag, "_ferr"}, cap_f[ch][idx], f);
        $display("frame %s ch%0d #%0d data=0x%02h perr=%0b ferr=%0b", tag, ch, idx,
                 cap_d[ch][idx], cap_p[ch][idx], cap_f[ch][idx]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // A glitched bit inverts the line for 20 clocks around its centre sample.
    task automatic drive_bit(input int ch, input logic v, input int bitclk, input bit gl);
        for (int i = 0; i < bitclk; i++) begin
            rx_line[ch] = (gl && i >= 205 && i < 225) ? ~v : v;
            @(negedge clk);
        end
    endtask

    task automatic send(input int ch, input logic [7:0] d, input bit use_par, input logic par,
                        input int nstop, input logic stop_v, input int bitclk, input int gl_bit);
        drive_bit(ch, 1'b0, bitclk, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(ch, d[i], bitclk, i == gl_bit);
        if (use_par) drive_bit(ch, par, bitclk, 1'b0);
        for (int i = 0; i < nstop; i++) drive_bit(ch, stop_v, bitclk, 1'b0);
        rx_line[ch] = 1'b1;
    endtask

    initial begin
        rst     = 1'b1;
        rx_line = 4'hF;
        idle(4);
        check("rst_data0", data_o[0], 8'h00);
        check("rst_data3", data_o[3], 8'h00);
        check("rst_flags", {valid_o, perr_o, ferr_o, busy_o}, 16'h0000);
        rst = 1'b0;
        idle(20);

        // Clean 8N1 frame
        send(0, 8'h55, 1'b0, 1'b0, 1, 1'b1, BIT, -1);
        idle(BIT);
        check("t1_count", vcnt[0], 1);
        check_frame("t1", 0, 0, 8'h55, 1'b0, 1'b0);
        check("t1_busy", busy_o[0], 1'b0);

        // Parity: even good, even bad, odd good (0xA7 has five ones)
        send(1, 8'hA7, 1'b1, 1'b1, 1, 1'b1, BIT, -1);
        idle(BIT);
        send(1, 8'hA7, 1'b1, 1'b0, 1, 1'b1, BIT, -1);
        idle(BIT);
        send(2, 8'hA7, 1'b1, 1'b0, 1, 1'b1, BIT, -1);
        idle(BIT);
        check("t2_count_even", vcnt[1], 2);
        check("t2_count_odd", vcnt[2], 1);
        check_frame("t2_even_ok", 1, 0, 8'hA7, 1'b0, 1'b0);
        check_frame("t2_even_bad", 1, 1, 8'hA7, 1'b1, 1'b0);
        check_frame("t2_odd_ok", 2, 0, 8'hA7, 1'b0, 1'b0);

        // Framing errors, including a break
        send(0, 8'h3C, 1'b0, 1'b0, 1, 1'b0, BIT, -1);
        idle(2 * BIT);
        send(0, 8'h00, 1'b0, 1'b0, 1, 1'b0, BIT, -1);
        idle(2 * BIT);
        check("t3_count", vcnt[0], 3);
        check_frame("t3_stop_low", 0, 1, 8'h3C, 1'b0, 1'b1);
        check_frame("t3_break", 0, 2, 8'h00, 1'b0, 1'b1);
        check("t3_busy", busy_o[0], 1'b0);

        // 100-clock low glitch on an idle line is a false start
        rx_line[0] = 1'b0;
        idle(50);
        check("t4_glitch_busy", busy_o[0], 1'b1);
        idle(50);
        rx_line[0] = 1'b1;
        idle(BIT);
        check("t4_glitch_idle", busy_o[0], 1'b0);
        check("t4_glitch_count", vcnt[0], 3);
        send(0, 8'hFF, 1'b0, 1'b0, 1, 1'b1, BIT, 3);
        idle(BIT);
        check("t4_count", vcnt[0], 4);
        check_frame("t4_vote", 0, 3, 8'hFF, 1'b0, 1'b0);

        // Back-to-back 8N2 frames with the transmitter 2% fast, then 2% slow
        send(3, 8'h12, 1'b0, 1'b0, 2, 1'b1, 423, -1);
        send(3, 8'h34, 1'b0, 1'b0, 2, 1'b1, 423, -1);
        send(3, 8'h56, 1'b0, 1'b0, 2, 1'b1, 423, -1);
        idle(BIT);
        send(3, 8'h12, 1'b0, 1'b0, 2, 1'b1, 441, -1);
        send(3, 8'h34, 1'b0, 1'b0, 2, 1'b1, 441, -1);
        send(3, 8'h56, 1'b0, 1'b0, 2, 1'b1, 441, -1);
        idle(BIT);
        check("t5_count", vcnt[3], 6);
        check_frame("t5_fast0", 3, 0, 8'h12, 1'b0, 1'b0);
        check_frame("t5_fast1", 3, 1, 8'h34, 1'b0, 1'b0);
        check_frame("t5_fast2", 3, 2, 8'h56, 1'b0, 1'b0);
        check_frame("t5_slow0", 3, 3, 8'h12, 1'b0, 1'b0);
        check_frame("t5_slow1", 3, 4, 8'h34, 1'b0, 1'b0);
        check_frame("t5_slow2", 3, 5, 8'h56, 1'b0, 1'b0);

        // Asynchronous reset during data bit 4; held until the frame ends
        fork
            send(0, 8'hC3, 1'b0, 1'b0, 1, 1'b1, BIT, -1);
            begin
                idle(5 * BIT + 200);
                check("t6_pre_busy", busy_o[0], 1'b1);
                check("t6_pre_data", data_o[0], 8'hFF);
                rst = 1'b1;
                #1;
                check("t6_rst_data0", data_o[0], 8'h00);
                check("t6_rst_data3", data_o[3], 8'h00);
                check("t6_rst_flags", {valid_o, perr_o, ferr_o, busy_o}, 16'h0000);
            end
        join
        idle(10);
        rst = 1'b0;
        idle(20);
        check("t6_no_partial", vcnt[0], 4);
        send(0, 8'hC3, 1'b0, 1'b0, 1, 1'b1, BIT, -1);
        idle(BIT);
        check("t6_count", vcnt[0], 5);
        check_frame("t6_after_rst", 0, 4, 8'hC3, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
